// File: rtl/count_seq_checker.sv
// Consumer-side monitor for a free-running up-counter: checks that each sample is the
// previous one plus one (mod 2^WIDTH), tracks lock, and flags errors and counter restarts.
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int ERR_W    = 8,
    parameter int SYNC_LEN = 2,
    parameter int LOSS_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             check_en,
    input  logic             clear_err,
    output logic             synced,
    output logic             error,
    output logic             restart,
    output logic [ERR_W-1:0] err_count
);

    localparam int GW = $clog2(SYNC_LEN + 1);
    localparam int LW = $clog2(LOSS_LEN + 1);
    localparam logic [GW-1:0] SYNC_MAX = GW'(SYNC_LEN);
    localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_LEN);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_vld_q, prev_vld_d;
    logic [GW-1:0]    good_cnt_q, good_cnt_d;
    logic [LW-1:0]    bad_cnt_q, bad_cnt_d;
    logic             synced_q, synced_d;
    logic             error_q, error_d;
    logic             restart_q, restart_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic match;
    logic is_zero;

    // Wrap from all-ones to zero is a legal increment thanks to the WIDTH truncation.
    assign match   = prev_vld_q && (count_in == prev_q + WIDTH'(1));
    assign is_zero = (count_in == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            synced_q    <= 1'b0;
            error_q     <= 1'b0;
            restart_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            synced_q    <= synced_d;
            error_q     <= error_d;
            restart_q   <= restart_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (!check_en) begin
            state_d    = IDLE;
            prev_vld_d = 1'b0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else begin
            prev_d     = count_in;
            prev_vld_d = 1'b1;
            case (state_q)
                IDLE: begin
                    state_d    = ACQUIRE;
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                end
                ACQUIRE: begin
                    if (match) begin
                        good_cnt_d = good_cnt_q + GW'(1);
                        if (good_cnt_q + GW'(1) == SYNC_MAX) begin
                            state_d   = LOCKED;
                            bad_cnt_d = '0;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        bad_cnt_d = '0;
                    end else if (is_zero) begin
                        state_d    = ACQUIRE;
                        good_cnt_d = '0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + LW'(1);
                        if (bad_cnt_q + LW'(1) == LOSS_MAX) begin
                            state_d    = ACQUIRE;
                            good_cnt_d = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A zero sample in lock is read as the counter being reset, not as a fault.
    always_comb begin
        error_d     = 1'b0;
        restart_d   = 1'b0;
        err_count_d = err_count_q;
        synced_d    = (state_d == LOCKED);
        if (check_en && state_q == LOCKED && !match) begin
            if (is_zero) begin
                restart_d = 1'b1;
            end else begin
                error_d = 1'b1;
            end
        end
        if (clear_err) begin
            err_count_d = '0;
        end else if (error_d && err_count_q != '1) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

    assign synced    = synced_q;
    assign error     = error_q;
    assign restart   = restart_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: lock acquisition, wrap, skips, loss of lock,
// restart detection, error-counter saturation/clear, async reset and enable drop.
module tb_count_seq_checker;

    logic       clk;
    logic       rst;
    logic [3:0] count_in;
    logic       check_en;
    logic       clear_err;
    logic       synced;
    logic       error;
    logic       restart;
    logic [7:0] err_count;

    int vectors;
    int miscompares;

    count_seq_checker #(
        .WIDTH(4), .ERR_W(8), .SYNC_LEN(2), .LOSS_LEN(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .check_en (check_en),
        .clear_err(clear_err),
        .synced   (synced),
        .error    (error),
        .restart  (restart),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample, let it be captured, then settle 1ns past the edge.
    task automatic applyStimulus(input logic [3:0] c, input logic en, input logic clr);
        count_in  = c;
        check_en  = en;
        clear_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkFlags(input string tag, input logic s, input logic e, input logic r, input int ec);
        checkOutput({tag, ".synced"}, {31'd0, synced}, {31'd0, s});
        checkOutput({tag, ".error"}, {31'd0, error}, {31'd0, e});
        checkOutput({tag, ".restart"}, {31'd0, restart}, {31'd0, r});
        checkOutput({tag, ".err_count"}, {24'd0, err_count}, 32'(ec));
    endtask

    initial begin
        int v;
        int nv;
        int nerr;
        int model_err;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        count_in    = '0;
        check_en    = 1'b0;
        clear_err   = 1'b0;
        #3;
        checkFlags("reset", 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Clean sequence with two wraps: lock on the edge capturing sample value 2.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(4'(i), 1'b1, 1'b0);
            checkFlags("wrap", (i >= 2), 1'b0, 1'b0, 0);
        end

        // Continue from 8 up to 3 (through a wrap), then 4,5,7,8.
        for (int i = 8; i < 20; i++) applyStimulus(4'(i), 1'b1, 1'b0);
        applyStimulus(4'd4, 1'b1, 1'b0);
        applyStimulus(4'd5, 1'b1, 1'b0);
        checkFlags("skip5", 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(4'd7, 1'b1, 1'b0);
        checkFlags("skip7", 1'b1, 1'b1, 1'b0, 1);
        applyStimulus(4'd8, 1'b1, 1'b0);
        checkFlags("skip8", 1'b1, 1'b0, 1'b0, 1);

        // Run up to 3, clearing the error count on the last sample, then 9,9,9.
        for (int i = 9; i < 19; i++) applyStimulus(4'(i), 1'b1, 1'b0);
        applyStimulus(4'd3, 1'b1, 1'b1);
        checkFlags("clr3", 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(4'd9, 1'b1, 1'b0);
        checkFlags("loss1", 1'b1, 1'b1, 1'b0, 1);
        applyStimulus(4'd9, 1'b1, 1'b0);
        checkFlags("loss2", 1'b1, 1'b1, 1'b0, 2);
        applyStimulus(4'd9, 1'b1, 1'b0);
        checkFlags("loss3", 1'b0, 1'b1, 1'b0, 3);
        applyStimulus(4'd10, 1'b1, 1'b0);
        checkFlags("relock10", 1'b0, 1'b0, 1'b0, 3);
        applyStimulus(4'd11, 1'b1, 1'b0);
        checkFlags("relock11", 1'b1, 1'b0, 1'b0, 3);
        applyStimulus(4'd12, 1'b1, 1'b0);
        checkFlags("relock12", 1'b1, 1'b0, 1'b0, 3);

        // Run to 6 (via the wrap), then a counter restart 0,1,2.
        for (int i = 13; i < 23; i++) applyStimulus(4'(i), 1'b1, 1'b0);
        checkFlags("at6", 1'b1, 1'b0, 1'b0, 3);
        applyStimulus(4'd0, 1'b1, 1'b0);
        checkFlags("rst0", 1'b0, 1'b0, 1'b1, 3);
        applyStimulus(4'd1, 1'b1, 1'b0);
        checkFlags("rst1", 1'b0, 1'b0, 1'b0, 3);
        applyStimulus(4'd2, 1'b1, 1'b0);
        checkFlags("rst2", 1'b1, 1'b0, 1'b0, 3);

        // Alternate skip/resume pairs so lock is kept while errors accumulate.
        v         = 2;
        nerr      = 0;
        model_err = 3;
        while (nerr < 300) begin
            nv = (v + 2) % 16;
            if (nv == 0) begin
                v = (v + 1) % 16;
                applyStimulus(4'(v), 1'b1, 1'b0);
            end else begin
                applyStimulus(4'(nv), 1'b1, 1'b0);
                nerr++;
                if (model_err < 255) model_err++;
                checkOutput("sat.error", {31'd0, error}, 32'd1);
                checkOutput("sat.err_count", {24'd0, err_count}, 32'(model_err));
                v = (nv + 1) % 16;
                applyStimulus(4'(v), 1'b1, 1'b0);
            end
        end
        checkFlags("sat.end", 1'b1, 1'b0, 1'b0, 255);

        nv = (v + 2) % 16;
        if (nv == 0) nv = (v + 3) % 16;
        applyStimulus(4'(nv), 1'b1, 1'b1);
        checkFlags("clr_vs_err", 1'b1, 1'b1, 1'b0, 0);
        v = (nv + 1) % 16;
        applyStimulus(4'(v), 1'b1, 1'b0);
        checkFlags("post_clr", 1'b1, 1'b0, 1'b0, 0);

        // Make the count non-zero again, then reset between edges.
        v = (v + 3) % 16;
        if (v == 0) v = 1;
        applyStimulus(4'(v), 1'b1, 1'b0);
        checkFlags("pre_rst", 1'b1, 1'b1, 1'b0, 1);
        #2;
        rst = 1'b1;
        #1;
        checkFlags("async_rst", 1'b0, 1'b0, 1'b0, 0);
        #2;
        rst = 1'b0;

        applyStimulus(4'd5, 1'b1, 1'b0);
        checkFlags("re5", 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(4'd6, 1'b1, 1'b0);
        checkFlags("re6", 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(4'd7, 1'b1, 1'b0);
        checkFlags("re7", 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(4'd9, 1'b1, 1'b0);
        checkFlags("re9", 1'b1, 1'b1, 1'b0, 1);
        applyStimulus(4'd10, 1'b1, 1'b0);
        checkFlags("re10", 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(4'd11, 1'b0, 1'b0);
        checkFlags("en_off", 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(4'd3, 1'b0, 1'b0);
        checkFlags("idle", 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(4'd4, 1'b1, 1'b0);
        checkFlags("idle_cap", 1'b0, 1'b0, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
